// File: rtl/branch_target_predictor.sv
// branch_target_predictor
// Fetch-side dynamic branch predictor: a direct-mapped, tagged table of
// 2-bit saturating counters and branch targets held in flops. Fetch gets a
// zero-latency hit/taken/target guess for pred_pc. Execute trains the table
// with every resolved conditional branch.
// Optional build macro TITAN_BP_STATS_EN adds the stat_updates and
// stat_mispredicts counters and their output ports.
module branch_target_predictor #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  output logic            mispredict,
  input  logic            flush
`ifdef TITAN_BP_STATS_EN
  ,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_LO  = IDX_W + 2;
  localparam int TAG_HI  = IDX_W + TAG_W + 1;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    ctr_e             ctr;
    logic [XLEN-1:0]  target;
  } entry_t;

  entry_t table_q [ENTRIES];

  logic [IDX_W-1:0] pred_idx;
  logic [TAG_W-1:0] pred_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  entry_t           pred_entry;
  entry_t           upd_entry;
  entry_t           upd_next;
  logic             upd_hit;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign pred_tag = pred_pc[TAG_HI:TAG_LO];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign upd_tag  = upd_pc[TAG_HI:TAG_LO];

  // Byte-offset bits and bits above the tag never take part in a lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[1:0], pred_pc[XLEN-1:TAG_HI+1],
                            upd_pc[1:0], upd_pc[XLEN-1:TAG_HI+1]};

  // Lookup: combinational read of the current table state, no bypass of a
  // same-cycle update.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // value just computed; every output gets a default first so no latch forms.
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = '0;
    pred_entry  = table_q[pred_idx];
    if (pred_entry.valid && (pred_entry.tag == pred_tag)) begin
      pred_hit    = 1'b1;
      pred_taken  = pred_entry.ctr[1];
      pred_target = pred_entry.target;
    end
  end

  // Update: next value of the entry addressed by upd_pc (train on hit,
  // allocate on miss).
  always_comb begin
    upd_entry = table_q[upd_idx];
    upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
    upd_next  = upd_entry;
    if (upd_hit) begin
      if (upd_taken) begin
        upd_next.target = upd_target;
        if (upd_entry.ctr != CTR_STRONG_T) begin
          upd_next.ctr = ctr_e'(upd_entry.ctr + 2'd1);
        end
      end else if (upd_entry.ctr != CTR_STRONG_NT) begin
        upd_next.ctr = ctr_e'(upd_entry.ctr - 2'd1);
      end
    end else begin
      upd_next.valid  = 1'b1;
      upd_next.tag    = upd_tag;
      upd_next.target = upd_target;
      upd_next.ctr    = upd_taken ? CTR_WEAK_T : CTR_WEAK_NT;
    end
  end

  // Table and mispredict register: flush clears every valid bit and wins
  // over a coincident update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the table is built from flops, so every entry is reset
      // explicitly; a RAM-based table could not be cleared this way.
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_WEAK_NT, target: '0};
      end
      mispredict <= 1'b0;
    end else begin
      mispredict <= upd_valid & (upd_taken ^ upd_pred_taken);
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          table_q[i].valid <= 1'b0;
        end
      end else if (upd_valid) begin
        table_q[upd_idx] <= upd_next;
      end
    end
  end

`ifdef TITAN_BP_STATS_EN
  // Free-running statistics; wrap naturally and survive flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      stat_updates <= stat_updates + 32'd1;
      if (upd_taken ^ upd_pred_taken) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor
// Directed-vector bench for branch_target_predictor with hand-computed
// expectations. Index = pc[7:2], tag = pc[15:8] with default parameters.
module tb_branch_target_predictor;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [XLEN-1:0] pred_pc = '0;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid = 1'b0;
  logic [XLEN-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic [XLEN-1:0] upd_target = '0;
  logic            upd_pred_taken = 1'b0;
  logic            mispredict;
  logic            flush = 1'b0;
`ifdef TITAN_BP_STATS_EN
  logic [31:0]     stat_updates;
  logic [31:0]     stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_target_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .pred_pc        (pred_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .mispredict     (mispredict),
    .flush          (flush)
`ifdef TITAN_BP_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reset asserted, held two edges, released at a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One update cycle; returns 1 time unit after the training edge.
  task automatic do_update(input logic [XLEN-1:0] pc, input logic taken,
                           input logic [XLEN-1:0] target, input logic pt,
                           input logic with_flush);
    @(negedge clk);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_target     = target;
    upd_pred_taken = pt;
    flush          = with_flush;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [XLEN-1:0] pc,
                        input logic hit, input logic taken,
                        input logic [XLEN-1:0] target);
    pred_pc = pc;
    #1;
    check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, taken});
    check({tag, "_target"}, pred_target, target);
  endtask

  initial begin
    // Reset state.
    do_reset();
    lookup("rst", 32'h100, 1'b0, 1'b0, 32'h0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);

    // First taken update allocates weak-T; issued prediction was NT.
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
    check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

    // Four more taken: saturate at strong-T; last target overwrites.
    for (int i = 0; i < 4; i++) begin
      do_update(32'h100, 1'b1, (i == 3) ? 32'h204 : 32'h200, 1'b1, 1'b0);
    end
    check("sat_mispredict", {31'd0, mispredict}, 32'd0);
    lookup("sat_t", 32'h100, 1'b1, 1'b1, 32'h204);

    // Not-taken walk down: 11->10->01->00, target never overwritten.
    do_update(32'h100, 1'b0, 32'h999, 1'b1, 1'b0);
    check("nt1_mispredict", {31'd0, mispredict}, 32'd1);
    lookup("nt1", 32'h100, 1'b1, 1'b1, 32'h204);
    do_update(32'h100, 1'b0, 32'h999, 1'b1, 1'b0);
    lookup("nt2", 32'h100, 1'b1, 1'b0, 32'h204);
    do_update(32'h100, 1'b0, 32'h999, 1'b0, 1'b0);
    check("nt3_mispredict", {31'd0, mispredict}, 32'd0);
    lookup("nt3", 32'h100, 1'b1, 1'b0, 32'h204);

    // Saturation at strong-NT: one more NT stays 00, then a taken gives 01.
    do_update(32'h100, 1'b0, 32'h999, 1'b0, 1'b0);
    do_update(32'h100, 1'b1, 32'h204, 1'b0, 1'b0);
    lookup("sat_nt", 32'h100, 1'b1, 1'b0, 32'h204);

    // Idle cycle after an update: mispredict falls back to 0.
    @(posedge clk);
    #1;
    check("idle_mispredict", {31'd0, mispredict}, 32'd0);

    // Same-cycle lookup and update at ctr=01: old value visible, then new.
    @(negedge clk);
    pred_pc        = 32'h100;
    upd_valid      = 1'b1;
    upd_pc         = 32'h100;
    upd_taken      = 1'b1;
    upd_target     = 32'h200;
    upd_pred_taken = 1'b0;
    #1;
    check("same_pre_taken", {31'd0, pred_taken}, 32'd0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    check("same_post_taken", {31'd0, pred_taken}, 32'd1);
    check("same_post_target", pred_target, 32'h200);

    // Alias eviction: 0x200 shares index 0 with 0x100 but has tag 0x02.
    do_update(32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    do_update(32'h200, 1'b0, 32'h300, 1'b0, 1'b0);
    lookup("evicted", 32'h100, 1'b0, 1'b0, 32'h0);
    lookup("alias", 32'h200, 1'b1, 1'b0, 32'h300);
    // Allocated NT entry is weak-NT: a single taken flips it.
    do_update(32'h200, 1'b1, 32'h304, 1'b0, 1'b0);
    lookup("alias_t", 32'h200, 1'b1, 1'b1, 32'h304);
    lookup("other_idx", 32'h104, 1'b0, 1'b0, 32'h0);

    // upd_valid=0 with live-looking fields: no training, no mispredict.
    @(negedge clk);
    upd_pc         = 32'h200;
    upd_taken      = 1'b0;
    upd_pred_taken = 1'b1;
    @(posedge clk);
    #1;
    check("noupd_mispredict", {31'd0, mispredict}, 32'd0);
    lookup("noupd", 32'h200, 1'b1, 1'b1, 32'h304);

    // Flush with a coincident update: update dropped, mispredict still seen.
    do_update(32'h104, 1'b1, 32'h400, 1'b1, 1'b0);
    lookup("pre_flush", 32'h104, 1'b1, 1'b1, 32'h400);
    do_update(32'h108, 1'b1, 32'h500, 1'b0, 1'b1);
    check("flush_mispredict", {31'd0, mispredict}, 32'd1);
    lookup("flush_a", 32'h200, 1'b0, 1'b0, 32'h0);
    lookup("flush_b", 32'h104, 1'b0, 1'b0, 32'h0);
    lookup("flush_c", 32'h108, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset between edges after training.
    do_update(32'h100, 1'b1, 32'h500, 1'b0, 1'b0);
    pred_pc = 32'h100;
    #1;
    check("pre_arst_hit", {31'd0, pred_hit}, 32'd1);
    check("pre_arst_mispredict", {31'd0, mispredict}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_hit", {31'd0, pred_hit}, 32'd0);
    check("arst_mispredict", {31'd0, mispredict}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // First update after reset allocates (weak-NT) rather than training.
    do_update(32'h100, 1'b0, 32'h600, 1'b0, 1'b0);
    lookup("post_arst", 32'h100, 1'b1, 1'b0, 32'h600);

`ifdef TITAN_BP_STATS_EN
    // Statistics: 5 updates, 2 mismatches, plus a flush that must not clear.
    do_reset();
    check("stat_rst_upd", stat_updates, 32'd0);
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
    do_update(32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    do_update(32'h100, 1'b0, 32'h200, 1'b1, 1'b0);
    do_update(32'h100, 1'b0, 32'h200, 1'b0, 1'b0);
    do_update(32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("stat_updates", stat_updates, 32'd5);
    check("stat_mispredicts", stat_mispredicts, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
